vdp_color_mix: RTL and testbench
================================

# vdp_color_mix

Final pixel stage of the VDP, directly downstream of the background generator and sprite generator. Each cycle it picks the winning pixel between the background and sprite layers, looks the result up in the on-chip colour RAM (CRAM), and emits 12-bit Game Gear RGB to the LCD/video output. The CPU-side CRAM write port, with the Game Gear two-byte latch, also lives here.

## Interface
Parameters: none.
- `clk`  in  1  pixel clock; one pixel per cycle
- `rst`  in  1  synchronous, active-high reset
- `pixel_x`  in  9  current pixel column; the same value fed to the background stage
- `pixel_y`  in  9  current pixel line
- `display_active`  in  1  high inside the active picture
- `bg_color`  in  6  background CRAM byte address: [5] palette, [4:1] index, [0]=0
- `bg_priority`  in  1  background tile priority bit
- `spr_color`  in  6  sprite CRAM byte address; same format, [5] is always 1
- `backdrop_index`  in  4  backdrop colour index, taken from the sprite palette
- `mask_left_col`  in  1  blank pixels 0–7 of each line to the backdrop colour
- `cram_we`  in  1  CPU CRAM write strobe, one cycle per byte
- `cram_addr`  in  6  CPU CRAM byte address
- `cram_wdata`  in  8  CPU write byte
- `red`, `green`, `blue`  out  4 each  pixel colour
- `pix_valid`  out  1  `display_active` delayed to align with the RGB outputs

## Operation
- Transparency:
  - A layer is transparent when its [4:1] field is 0.
  - The index field is always bits [4:1] of the layer colour.
- Select, in priority order:
  1. `display_active`=0 → output black.
  2. Left mask (see Configuration) → backdrop.
  3. Sprite opaque and not (`bg_priority` and background opaque) → sprite.
  4. Otherwise → background.
- The backdrop entry is {1, `backdrop_index`}.
- The background is never replaced by the backdrop. A transparent background pixel shows its own entry 0 or 16.
- CRAM holds 32 entries × 12 bits: [3:0] R, [7:4] G, [11:8] B.
- CPU write to an even byte address:
  - Stores `cram_wdata` into an 8-bit latch.
  - Leaves CRAM unchanged.
- CPU write to an odd byte address:
  - Writes entry `cram_addr`[5:1] with {`cram_wdata`[3:0], latch}.
  - Ignores `cram_wdata`[7:4].
  - The latch keeps its value.
- An odd-address write with no preceding even-address write uses the current latch value, which is 0 after reset.

## Timing
- Two-stage pipeline; latency is 2 cycles from inputs to `red`/`green`/`blue`/`pix_valid`.
  - Stage 1 registers the selected 5-bit entry and the blank flag.
  - Stage 2 registers the CRAM read data.
- When a CPU write and a pixel read hit the same entry in the same cycle, the read returns the old value (read-before-write). The new value is visible to reads issued one cycle later.
- The CPU write port has no backpressure. Writes are accepted every cycle, including back-to-back even/odd pairs.
- Reset values:
  - RGB = 0, `pix_valid` = 0, latch = 0, all CRAM entries = 0, pipeline registers = 0.
- Reset asserted mid-frame:
  - Outputs read 0 on the cycle after the reset edge.
  - After release, valid pixels appear 2 cycles after the first `display_active`.
- A write coincident with `rst` is discarded.

## Configuration
- Macro: `VDP_LEFT_MASK_EN`.
- Defined:
  - When `mask_left_col`=1 and `pixel_x` < 8, the pixel is forced to the backdrop entry.
  - This takes precedence over the sprite and background layers.
- Undefined:
  - `mask_left_col` is ignored.
  - Columns 0–7 mix normally.

## Structure
- Package `vdp_pkg` holds:
  - `CRAM_ENTRIES` = 32, `CRAM_WIDTH` = 12, `LEFT_MASK_COLS` = 8, `PIPE_LAT` = 2.
  - An `is_transparent(color[5:0])` function, shared with the sprite stage.
- Sub-module `vdp_cram` contains:
  - The 32×12 flop array with synchronous reset.
  - The even/odd byte latch.
  - One registered read port.
- The top level contains the select logic and the delay line for `pix_valid`.

## Test plan
- Write 0x3F to byte address 0x02, then 0x0A to 0x03. Drive bg_color=0x02, active=1 → 2 cycles later R=F, G=3, B=A, pix_valid=1.
- Sprite opaque 0x22, background opaque with priority=1 → background colour. With priority=0 → sprite colour. With background index 0 and priority=1 → sprite colour.
- Both layers transparent (bg_color=0x00) → CRAM entry 0 is output, not the backdrop.
- `VDP_LEFT_MASK_EN` defined, mask=1, backdrop_index=5, pixel_x=7 → entry 21 colour. At pixel_x=8 → normal mix. Repeat with the macro undefined → normal mix at pixel_x=7.
- Same-cycle pixel read and CPU odd write to entry 1 → old RGB, then the new RGB on the following pixel.
- Assert rst mid-line after CRAM is loaded → RGB=0 and pix_valid=0 next cycle. All entries read 0 after release.

Source files
------------

// File: rtl/vdp_pkg.sv
// Shared VDP definitions: CRAM geometry, left-column mask width, pixel
// pipeline latency and the layer transparency test used by the mixer and
// the sprite stage.
package vdp_pkg;

    localparam int CRAM_ENTRIES   = 32;
    localparam int CRAM_WIDTH     = 12;
    localparam int LEFT_MASK_COLS = 8;
    localparam int PIPE_LAT       = 2;

    // A layer pixel is transparent when its colour index field is zero;
    // the palette bit and the byte-select bit do not take part.
    function automatic logic is_transparent(input logic [5:0] color);
        return (color[4:1] == 4'd0);
    endfunction

endpackage

// File: rtl/vdp_cram.sv
// Colour RAM: 32 x 12-bit entries ({B,G,R}) held in flops, written by the CPU
// through the Game Gear even/odd byte latch and read once per pixel through
// a registered port.
//
// The CPU write is registered once before it reaches the array so that it
// commits in step with the pixel that was presented alongside it. A pixel
// and a write presented in the same cycle therefore read the old entry
// value, and the next pixel sees the new one.
module vdp_cram
    import vdp_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cpu_we,
    input  logic [5:0]            cpu_addr,
    input  logic [7:0]            cpu_wdata,
    input  logic                  rd_en,
    input  logic [4:0]            rd_addr,
    output logic [CRAM_WIDTH-1:0] rd_data
);

    logic                  we_p1;
    logic [5:0]            addr_p1;
    logic [7:0]            wdata_p1;
    logic [7:0]            latch;
    logic [CRAM_WIDTH-1:0] mem [CRAM_ENTRIES];

    // Register the CPU write; a write presented during reset is dropped
    always_ff @(posedge clk) begin
        if (rst) begin
            we_p1    <= 1'b0;
            addr_p1  <= '0;
            wdata_p1 <= '0;
        end else begin
            we_p1    <= cpu_we;
            addr_p1  <= cpu_addr;
            wdata_p1 <= cpu_wdata;
        end
    end

    // Byte latch, entry update and registered read (old data on a collision)
    always_ff @(posedge clk) begin
        if (rst) begin
            latch   <= '0;
            rd_data <= '0;
            for (int i = 0; i < CRAM_ENTRIES; i++) begin
                mem[i] <= '0;
            end
        end else begin
            rd_data <= rd_en ? mem[rd_addr] : '0;
            if (we_p1) begin
                if (addr_p1[0]) begin
                    mem[addr_p1[5:1]] <= {wdata_p1[3:0], latch};
                end else begin
                    latch <= wdata_p1;
                end
            end
        end
    end

endmodule

// File: rtl/vdp_color_mix.sv
// VDP final pixel stage: picks background or sprite, looks the winner up in
// CRAM and drives 12-bit RGB two cycles later, with pix_valid aligned.
// Optional feature macro: VDP_LEFT_MASK_EN forces columns 0-7 to the
// backdrop colour while mask_left_col is high.
module vdp_color_mix
    import vdp_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [8:0] pixel_x,
    input  logic [8:0] pixel_y,
    input  logic       display_active,
    input  logic [5:0] bg_color,
    input  logic       bg_priority,
    input  logic [5:0] spr_color,
    input  logic [3:0] backdrop_index,
    input  logic       mask_left_col,
    input  logic       cram_we,
    input  logic [5:0] cram_addr,
    input  logic [7:0] cram_wdata,
    output logic [3:0] red,
    output logic [3:0] green,
    output logic [3:0] blue,
    output logic       pix_valid
);

    logic                  mask_hit;
    logic [4:0]            entry_p0;
    logic                  blank_p0;
    logic [4:0]            entry_p1;
    logic                  blank_p1;
    logic                  vld_p1;
    logic                  vld_p2;
    logic [CRAM_WIDTH-1:0] rgb_p2;
    logic                  unused_inputs;

`ifdef VDP_LEFT_MASK_EN
    assign mask_hit      = mask_left_col && (pixel_x < 9'(LEFT_MASK_COLS));
    assign unused_inputs = ^pixel_y;
`else
    assign mask_hit      = 1'b0;
    assign unused_inputs = ^{pixel_y, pixel_x, mask_left_col};
`endif

    // Layer select; a transparent background still shows its own entry 0/16
    always_comb begin
        entry_p0 = bg_color[5:1];
        blank_p0 = 1'b0;
        if (!display_active) begin
            entry_p0 = '0;
            blank_p0 = 1'b1;
        end else if (mask_hit) begin
            entry_p0 = {1'b1, backdrop_index};
        end else if (!is_transparent(spr_color) &&
                     !(bg_priority && !is_transparent(bg_color))) begin
            entry_p0 = spr_color[5:1];
        end
    end

    // ---- stage 1: selected entry, blank flag, valid ----
    always_ff @(posedge clk) begin
        if (rst) begin
            entry_p1 <= '0;
            blank_p1 <= 1'b0;
            vld_p1   <= 1'b0;
        end else begin
            entry_p1 <= entry_p0;
            blank_p1 <= blank_p0;
            vld_p1   <= display_active;
        end
    end

    // ---- stage 2: CRAM read data (inside vdp_cram) and valid ----
    vdp_cram u_cram (
        .clk       (clk),
        .rst       (rst),
        .cpu_we    (cram_we),
        .cpu_addr  (cram_addr),
        .cpu_wdata (cram_wdata),
        .rd_en     (vld_p1 && !blank_p1),
        .rd_addr   (entry_p1),
        .rd_data   (rgb_p2)
    );

    // Valid delay matching the CRAM read register
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p2 <= 1'b0;
        end else begin
            vld_p2 <= vld_p1;
        end
    end

    assign red       = rgb_p2[3:0];
    assign green     = rgb_p2[7:4];
    assign blue      = rgb_p2[11:8];
    assign pix_valid = vld_p2;

endmodule

// File: tb/tb_vdp_color_mix.sv
// Testbench for vdp_color_mix: randomized and directed pixels/CPU writes
// checked against a behavioural model of the CRAM and layer rules.
`timescale 1ns/1ps
module tb_vdp_color_mix;
    import vdp_pkg::*;

`ifdef VDP_LEFT_MASK_EN
    localparam bit MASK_ON = 1'b1;
`else
    localparam bit MASK_ON = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [8:0] pixel_x;
    logic [8:0] pixel_y;
    logic       display_active;
    logic [5:0] bg_color;
    logic       bg_priority;
    logic [5:0] spr_color;
    logic [3:0] backdrop_index;
    logic       mask_left_col;
    logic       cram_we;
    logic [5:0] cram_addr;
    logic [7:0] cram_wdata;
    logic [3:0] red, green, blue;
    logic       pix_valid;

    always #5 clk = ~clk;

    vdp_color_mix dut (
        .clk            (clk),
        .rst            (rst),
        .pixel_x        (pixel_x),
        .pixel_y        (pixel_y),
        .display_active (display_active),
        .bg_color       (bg_color),
        .bg_priority    (bg_priority),
        .spr_color      (spr_color),
        .backdrop_index (backdrop_index),
        .mask_left_col  (mask_left_col),
        .cram_we        (cram_we),
        .cram_addr      (cram_addr),
        .cram_wdata     (cram_wdata),
        .red            (red),
        .green          (green),
        .blue           (blue),
        .pix_valid      (pix_valid)
    );

    // Reference state: CRAM contents, byte latch, expected outputs in flight
    logic [11:0] cram_m [32];
    logic [7:0]  latch_m;
    logic [12:0] hist [PIPE_LAT];
    logic [12:0] exp_now;
    int pass_cnt  = 0;
    int total_cnt = 0;

    // Expected {valid, B, G, R} for the pixel currently on the inputs
    function automatic logic [12:0] ref_pixel();
        logic [4:0] ent;
        logic       bg_vis, spr_vis;
        if (!display_active) return 13'd0;
        bg_vis  = (bg_color[4:1] != 4'd0);
        spr_vis = (spr_color[4:1] != 4'd0);
        if (MASK_ON && mask_left_col && pixel_x < 9'd8)
            ent = {1'b1, backdrop_index};
        else if (spr_vis && !(bg_priority && bg_vis))
            ent = spr_color[5:1];
        else
            ent = bg_color[5:1];
        return {1'b1, cram_m[ent]};
    endfunction

    // Advance one pixel: update the model with this cycle's inputs, then
    // wait a clock and expose the expectation for what is now on the outputs
    task automatic step();
        logic [12:0] e;
        e = rst ? 13'd0 : ref_pixel();
        if (rst) begin
            for (int i = 0; i < 32; i++) cram_m[i] = 12'd0;
            latch_m = 8'd0;
            for (int i = 0; i < PIPE_LAT; i++) hist[i] = 13'd0;
        end else if (cram_we) begin
            if (cram_addr[0]) cram_m[cram_addr[5:1]] = {cram_wdata[3:0], latch_m};
            else              latch_m = cram_wdata;
        end
        for (int i = 0; i < PIPE_LAT - 1; i++) hist[i] = hist[i+1];
        hist[PIPE_LAT-1] = e;
        @(posedge clk);
        @(negedge clk);
        exp_now = hist[0];
    endtask

    task automatic idle_inputs();
        display_active = 1'b0;
        pixel_x        = 9'd100;
        pixel_y        = 9'd10;
        bg_color       = 6'h00;
        bg_priority    = 1'b0;
        spr_color      = 6'h20;
        backdrop_index = 4'd0;
        mask_left_col  = 1'b0;
        cram_we        = 1'b0;
        cram_addr      = 6'd0;
        cram_wdata     = 8'd0;
    endtask

    // Even byte then odd byte for one entry; upper nibble of the odd byte is junk
    task automatic write_entry(input int idx, input logic [11:0] val);
        display_active = 1'b0;
        cram_we    = 1'b1;
        cram_addr  = {idx[4:0], 1'b0};
        cram_wdata = val[7:0];
        step();
        cram_addr  = {idx[4:0], 1'b1};
        cram_wdata = {4'($urandom), val[11:8]};
        step();
        cram_we    = 1'b0;
    endtask

    task automatic load_all();
        for (int i = 0; i < 32; i++) write_entry(i, 12'(i * 139 + 7));
    endtask

    task automatic test_reset();
        rst = 1'b1;
        display_active = 1'b1;
        bg_color = 6'h06;
        for (int i = 0; i < 3; i++) begin
            step();
            total_cnt++;
            if ({pix_valid, blue, green, red} !== exp_now)
                $display("FAIL reset: got %h expected %h", {pix_valid, blue, green, red}, exp_now);
            else pass_cnt++;
        end
        rst = 1'b0;
        idle_inputs();
    endtask

    task automatic test_known_vector();
        cram_we = 1'b1; cram_addr = 6'h02; cram_wdata = 8'h3F; step();
        cram_addr = 6'h03; cram_wdata = 8'h0A; step();
        cram_we = 1'b0;
        display_active = 1'b1; bg_color = 6'h02; spr_color = 6'h20; bg_priority = 1'b0;
        step();
        display_active = 1'b0;
        step();
        total_cnt++;
        if ({pix_valid, blue, green, red} !== 13'h1A3F)
            $display("FAIL known_vector: got %h expected %h", {pix_valid, blue, green, red}, 13'h1A3F);
        else pass_cnt++;
        total_cnt++;
        if ({pix_valid, blue, green, red} !== exp_now)
            $display("FAIL known_vector_model: got %h expected %h", {pix_valid, blue, green, red}, exp_now);
        else pass_cnt++;
        step();
    endtask

    task automatic test_priority();
        logic [5:0] bgs [4] = '{6'h04, 6'h04, 6'h00, 6'h24};
        logic       pri [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
        load_all();
        for (int i = 0; i < 4 + PIPE_LAT; i++) begin
            display_active = (i < 4);
            if (i < 4) begin
                bg_color = bgs[i]; bg_priority = pri[i]; spr_color = 6'h22;
            end
            step();
            total_cnt++;
            if ({pix_valid, blue, green, red} !== exp_now)
                $display("FAIL priority[%0d]: got %h expected %h", i, {pix_valid, blue, green, red}, exp_now);
            else pass_cnt++;
        end
    endtask

    task automatic test_transparent();
        logic [5:0] bgs [2] = '{6'h00, 6'h20};
        backdrop_index = 4'd7;
        for (int i = 0; i < 2 + PIPE_LAT; i++) begin
            display_active = (i < 2);
            if (i < 2) begin
                bg_color = bgs[i]; spr_color = 6'h20; bg_priority = 1'b0;
            end
            step();
            total_cnt++;
            if ({pix_valid, blue, green, red} !== exp_now)
                $display("FAIL transparent[%0d]: got %h expected %h", i, {pix_valid, blue, green, red}, exp_now);
            else pass_cnt++;
        end
    endtask

    task automatic test_left_mask();
        logic [8:0] xs [4] = '{9'd7, 9'd8, 9'd0, 9'd3};
        logic       ms [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
        backdrop_index = 4'd5;
        for (int i = 0; i < 4 + PIPE_LAT; i++) begin
            display_active = (i < 4);
            if (i < 4) begin
                pixel_x = xs[i]; mask_left_col = ms[i];
                bg_color = 6'h06; spr_color = 6'h2A; bg_priority = 1'b0;
            end
            step();
            total_cnt++;
            if ({pix_valid, blue, green, red} !== exp_now)
                $display("FAIL left_mask[%0d]: got %h expected %h", i, {pix_valid, blue, green, red}, exp_now);
            else pass_cnt++;
        end
        mask_left_col = 1'b0;
        pixel_x = 9'd100;
    endtask

    task automatic test_collision();
        display_active = 1'b0;
        cram_we = 1'b1; cram_addr = 6'h02; cram_wdata = 8'h5C; step();
        for (int i = 0; i < 2 + PIPE_LAT; i++) begin
            display_active = (i < 2);
            bg_color = 6'h02; spr_color = 6'h20; bg_priority = 1'b0;
            cram_we    = (i == 0);
            cram_addr  = 6'h03;
            cram_wdata = 8'hE7;
            step();
            total_cnt++;
            if ({pix_valid, blue, green, red} !== exp_now)
                $display("FAIL collision[%0d]: got %h expected %h", i, {pix_valid, blue, green, red}, exp_now);
            else pass_cnt++;
        end
        cram_we = 1'b0;
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            display_active = ($urandom_range(0, 9) < 8);
            pixel_x        = 9'($urandom_range(0, 15));
            bg_color       = {1'($urandom), 4'($urandom), 1'b0};
            spr_color      = {1'b1, 4'($urandom), 1'b0};
            bg_priority    = 1'($urandom);
            backdrop_index = 4'($urandom);
            mask_left_col  = 1'($urandom);
            cram_we        = ($urandom_range(0, 2) == 0);
            cram_addr      = 6'($urandom);
            cram_wdata     = 8'($urandom);
            step();
            total_cnt++;
            if ({pix_valid, blue, green, red} !== exp_now)
                $display("FAIL random[%0d]: got %h expected %h", i, {pix_valid, blue, green, red}, exp_now);
            else pass_cnt++;
        end
        idle_inputs();
    endtask

    task automatic test_midline_reset();
        load_all();
        display_active = 1'b1; bg_color = 6'h0A; spr_color = 6'h20;
        step();
        rst = 1'b1;
        cram_we = 1'b1; cram_addr = 6'h03; cram_wdata = 8'h0F;
        step();
        total_cnt++;
        if ({pix_valid, blue, green, red} !== 13'd0)
            $display("FAIL midline_reset: got %h expected %h", {pix_valid, blue, green, red}, 13'd0);
        else pass_cnt++;
        rst = 1'b0;
        cram_we = 1'b0;
        for (int i = 0; i < 32 + PIPE_LAT; i++) begin
            display_active = (i < 32);
            bg_color = {i[4:0], 1'b0};
            spr_color = 6'h20;
            step();
            total_cnt++;
            if ({pix_valid, blue, green, red} !== exp_now)
                $display("FAIL post_reset[%0d]: got %h expected %h", i, {pix_valid, blue, green, red}, exp_now);
            else pass_cnt++;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 32; i++) cram_m[i] = 12'd0;
        latch_m = 8'd0;
        for (int i = 0; i < PIPE_LAT; i++) hist[i] = 13'd0;
        exp_now = 13'd0;
        rst = 1'b1;
        idle_inputs();
        @(negedge clk);
        test_reset();
        test_known_vector();
        test_priority();
        test_transparent();
        test_left_mask();
        test_collision();
        test_random();
        test_midline_reset();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
